stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Round-robin arbiter that merges `NUM_INPUTS` valid/ready streams onto one registered output stream, sharing a single downstream consumer between requesters. It optionally holds a grant for a whole multi-beat packet (delimited by `last`) and tags every output beat with the index of its source. The block sits in front of shared stream resources such as memory ports or shared pipeline stages, using the same valid/ready semantics as the rest of the stream library.

## Interface
- `NUM_INPUTS`, default 4: number of requesting streams; must be at least 2.
- `DATA_WIDTH`, default 32: payload width per stream.
- `LOCK_ON_LAST`, default 1: if 1, a grant is held until a beat with `last`=1 is accepted; if 0, arbitration happens on every beat.
- `ID_WIDTH`, default `$clog2(NUM_INPUTS)`: width of the source index.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_input`  in  NUM_INPUTS  per-stream valid.
- `ready_input`  out  NUM_INPUTS  per-stream ready; one-hot or all zero.
- `data_input`  in  NUM_INPUTS*DATA_WIDTH  payloads; stream i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `last_input`  in  NUM_INPUTS  end-of-packet flag per stream.
- `valid_output`  out  1  output beat present.
- `ready_output`  in  1  downstream accepts.
- `data_output`  out  DATA_WIDTH  registered payload.
- `last_output`  out  1  registered last.
- `id_output`  out  ID_WIDTH  index of the source stream of the current output beat.

## Operation
- The output is a one-entry register. Define `load = !valid_output || ready_output`.
- **Arbitration:**
  - Only when `load`=1 is a grant issued.
  - The grant goes to the first i with `valid_input[i]`=1, scanning from `pointer` upward modulo NUM_INPUTS.
  - `ready_input[i]` = `load` && (i == grant) && `valid_input[i]`.
- **Accept:** when `ready_input[g]` is asserted, the output register takes `data_input[g]`, `last_input[g]` and `id`=g, and `valid_output` becomes 1.
  - If `load`=1 and no input is accepted, `valid_output` becomes 0.
- **State machine (only when LOCK_ON_LAST=1):**
  - UNLOCKED → LOCKED(g) when a beat with `last`=0 is accepted from g.
  - LOCKED(g) → UNLOCKED when a beat with `last`=1 is accepted from g.
  - In LOCKED(g), the grant is forced to g and every other stream sees `ready_input`=0, even if g is idle. The lock is never abandoned mid-packet.
- **Pointer update:**
  - When a beat with `last`=1 is accepted from g (or any beat when LOCK_ON_LAST=0), `pointer` becomes (g+1) mod NUM_INPUTS.
  - Otherwise `pointer` holds.
  - Wrap-around: after the top index, the pointer returns to 0.
- With LOCK_ON_LAST=0, the block never enters LOCKED, and `last` is passed through without being interpreted.
- **Simultaneous accept and drain:** when `ready_output`=1 and an input is accepted in the same cycle, the register is overwritten. No bubble and no loss.
- **Stability:** while `valid_output`=1 and `ready_output`=0, `data_output`, `last_output` and `id_output` hold stable.

## Timing
- **Reset** (synchronous, takes priority over everything):
  - `valid_output`=0, `data_output`=0, `last_output`=0, `id_output`=0.
  - `pointer`=0; state = UNLOCKED.
  - `ready_input` is 0 while `rst`=1.
- **Reset mid-packet:** the lock is dropped and the in-flight output beat is discarded. Upstream retransmission is the sender's concern.
- **Latency:** a beat accepted in cycle N is on the output in cycle N+1.
- **Throughput:** 1 beat/cycle while `ready_output` is held high.
- **Combinational paths:**
  - `ready_input` depends combinationally on `valid_input`, `ready_output`, `pointer` and the lock state.
  - The output signals are purely registered.
- **Fairness:** each requester waits at most NUM_INPUTS-1 packets before being granted.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all valids high → `valid_output`=0 and `ready_input`=0 during reset. The first grant after reset goes to stream 0.
- **Round-robin:** NUM_INPUTS=4, LOCK_ON_LAST=1, all four streams continuously valid with single-beat packets (`last`=1), `ready_output`=1 → `id_output` sequence 0,1,2,3,0,…, one beat per cycle with no bubbles.
- **Packet lock:**
  - Stream 1 sends 3 beats (last on beat 3) while stream 2 is valid throughout → `id_output`=1,1,1,2.
  - Stream 1 goes idle for 2 cycles mid-packet → stream 2 still sees `ready_input[2]`=0 until stream 1's last beat is accepted.
- **Backpressure:** `ready_output`=0 for 5 cycles with `valid_output`=1 and data A → `data_output` stays A and all `ready_input`=0. Release `ready_output` → A is taken and the next beat B appears the following cycle.
- **Pointer wrap and sparse requests:**
  - Only streams 3 and 0 valid, pointer=3 → order 3,0,3,0.
  - With LOCK_ON_LAST=0 and stream 2 sending beats with `last`=0 while stream 3 is valid → the streams alternate per beat.
- **Reset mid-packet:** assert `rst` while in LOCKED(2) with `valid_output`=1 → the next cycle `valid_output`=0 and state is UNLOCKED. After reset, stream 0 (if valid) is granted ahead of stream 2.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_INPUTS valid/ready streams onto one registered
// output stream, with optional packet locking and a source-index tag per beat.
module stream_rr_arbiter #(
    parameter int NUM_INPUTS   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int LOCK_ON_LAST = 1,
    parameter int ID_WIDTH     = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS-1:0]            valid_input,
    output logic [NUM_INPUTS-1:0]            ready_input,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_input,
    input  logic [NUM_INPUTS-1:0]            last_input,
    output logic                             valid_output,
    input  logic                             ready_output,
    output logic [DATA_WIDTH-1:0]            data_output,
    output logic                             last_output,
    output logic [ID_WIDTH-1:0]              id_output
);

    localparam int CW = ID_WIDTH + 1;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t                stateQ, stateD;
    logic [ID_WIDTH-1:0]   lockIdQ, lockIdD;
    logic [ID_WIDTH-1:0]   pointerQ, pointerD;
    logic                  validQ, validD;
    logic [DATA_WIDTH-1:0] dataQ, dataD;
    logic                  lastQ, lastD;
    logic [ID_WIDTH-1:0]   idQ, idD;

    logic [ID_WIDTH-1:0]   grantIdx;
    logic [ID_WIDTH-1:0]   candIdx;
    logic [CW-1:0]         candSum;
    logic                  grantValid;
    logic                  load;
    logic                  accept;
    logic [DATA_WIDTH-1:0] selData;
    logic                  selLast;

    assign load = !validQ || ready_output;

    // A locked packet owns the grant even while its source is idle.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        candSum    = '0;
        candIdx    = '0;
        if (stateQ == LOCKED) begin
            grantIdx   = lockIdQ;
            grantValid = valid_input[lockIdQ];
        end else begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                candSum = CW'(pointerQ) + CW'(k);
                if (candSum >= CW'(NUM_INPUTS)) begin
                    candSum = candSum - CW'(NUM_INPUTS);
                end
                candIdx = candSum[ID_WIDTH-1:0];
                if (!grantValid && valid_input[candIdx]) begin
                    grantValid = 1'b1;
                    grantIdx   = candIdx;
                end
            end
        end
    end

    always_comb begin
        ready_input = '0;
        if (!rst && load && grantValid) begin
            ready_input[grantIdx] = 1'b1;
        end
    end

    assign accept = |ready_input;

    always_comb begin
        selData = '0;
        selLast = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grantIdx == ID_WIDTH'(i)) begin
                selData = data_input[i*DATA_WIDTH +: DATA_WIDTH];
                selLast = last_input[i];
            end
        end
    end

    always_comb begin
        stateD   = stateQ;
        lockIdD  = lockIdQ;
        pointerD = pointerQ;
        validD   = validQ;
        dataD    = dataQ;
        lastD    = lastQ;
        idD      = idQ;
        if (load) begin
            validD = accept;
        end
        if (accept) begin
            dataD = selData;
            lastD = selLast;
            idD   = grantIdx;
            if (selLast || LOCK_ON_LAST == 0) begin
                pointerD = (grantIdx == ID_WIDTH'(NUM_INPUTS - 1)) ? '0 : grantIdx + ID_WIDTH'(1);
            end
            if (LOCK_ON_LAST != 0) begin
                stateD  = selLast ? UNLOCKED : LOCKED;
                lockIdD = grantIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= UNLOCKED;
            lockIdQ  <= '0;
            pointerQ <= '0;
            validQ   <= 1'b0;
            dataQ    <= '0;
            lastQ    <= 1'b0;
            idQ      <= '0;
        end else begin
            stateQ   <= stateD;
            lockIdQ  <= lockIdD;
            pointerQ <= pointerD;
            validQ   <= validD;
            dataQ    <= dataD;
            lastQ    <= lastD;
            idQ      <= idD;
        end
    end

    assign valid_output = validQ;
    assign data_output  = dataQ;
    assign last_output  = lastQ;
    assign id_output    = idQ;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Table-driven bench for stream_rr_arbiter: per-cycle expected ready_input vectors
// plus a scoreboard of expected output beats (locking and non-locking instances).
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    validIn;
    logic [N-1:0]    lastIn;
    logic [N*DW-1:0] dataIn;
    logic            readyOut;
    logic            sel;

    logic [N-1:0]    ready0, ready1, readyIn;
    logic            valid0, valid1, validOut;
    logic [DW-1:0]   data0, data1, dataOut;
    logic            last0, last1, lastOut;
    logic [IW-1:0]   id0, id1, idOut;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .LOCK_ON_LAST(1)) dutLock (
        .clk(clk), .rst(rst),
        .valid_input(validIn), .ready_input(ready0), .data_input(dataIn), .last_input(lastIn),
        .valid_output(valid0), .ready_output(readyOut), .data_output(data0),
        .last_output(last0), .id_output(id0)
    );

    stream_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .LOCK_ON_LAST(0)) dutFree (
        .clk(clk), .rst(rst),
        .valid_input(validIn), .ready_input(ready1), .data_input(dataIn), .last_input(lastIn),
        .valid_output(valid1), .ready_output(readyOut), .data_output(data1),
        .last_output(last1), .id_output(id1)
    );

    assign readyIn  = sel ? ready1 : ready0;
    assign validOut = sel ? valid1 : valid0;
    assign dataOut  = sel ? data1  : data0;
    assign lastOut  = sel ? last1  : last0;
    assign idOut    = sel ? id1    : id0;

    typedef struct {
        logic         r;
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic         ro;
        logic [N-1:0] e;
        logic         s;
    } vec_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    vec_t  tbl[$];
    beat_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    curVec      = 0;
    logic  expValid    = 1'b0;

    function automatic vec_t mk(logic r, logic [N-1:0] v, logic [N-1:0] l, logic ro,
                                logic [N-1:0] e, logic s);
        vec_t t;
        t.r = r; t.v = v; t.l = l; t.ro = ro; t.e = e; t.s = s;
        return t;
    endfunction

    function automatic logic [DW-1:0] dataFor(int s, int v);
        return {8'(s), 8'(v), 16'hC0DE};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s (vector %0d): actual %0h, required %0h", name, curVec, act, exp);
        end
    endtask

    // Output beat is compared against the oldest expected beat; popped on handshake.
    task automatic checkOutput(input vec_t t);
        beat_t b;
        check("ready_input", 64'(readyIn), 64'(t.e));
        check("valid_output", 64'(validOut), 64'(expValid));
        if (validOut) begin
            if (sb.size() == 0) begin
                check("unexpectedBeat", 64'(1), 64'(0));
            end else begin
                check("id_output", 64'(idOut), 64'(sb[0].id));
                check("data_output", 64'(dataOut), 64'(sb[0].data));
                check("last_output", 64'(lastOut), 64'(sb[0].last));
                if (t.ro && !t.r) void'(sb.pop_front());
            end
        end
        for (int i = 0; i < N; i++) begin
            if (t.e[i]) begin
                b.id   = IW'(i);
                b.data = dataFor(i, curVec);
                b.last = t.l[i];
                sb.push_back(b);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        @(negedge clk);
        rst      = t.r;
        validIn  = t.v;
        lastIn   = t.l;
        readyOut = t.ro;
        sel      = t.s;
        for (int i = 0; i < N; i++) dataIn[i*DW +: DW] = dataFor(i, curVec);
        #1;
        checkOutput(t);
        @(posedge clk);
        if (t.r) begin
            expValid = 1'b0;
            sb.delete();
        end else if (!expValid || t.ro) begin
            expValid = (t.e != '0);
        end
    endtask

    initial begin
        rst = 1'b1; validIn = '0; lastIn = '0; dataIn = '0; readyOut = 1'b0; sel = 1'b0;

        // reset with all streams requesting
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b0000, 0));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b0000, 0));
        // round robin, single-beat packets, no bubbles
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 0));
        // stream 1 three-beat packet while stream 2 waits
        tbl.push_back(mk(0, 4'b0110, 4'b0100, 1, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0110, 4'b0100, 1, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0110, 4'b0110, 1, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 0));
        // stream 1 idles mid-packet; stream 2 stays blocked
        tbl.push_back(mk(0, 4'b0110, 4'b0100, 1, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0110, 4'b0110, 1, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 0));
        // backpressure: beat A held 5 cycles, then B
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 1, 4'b1000, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0001, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0));
        // move pointer to 3, then sparse requests on 3 and 0
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 0));
        tbl.push_back(mk(0, 4'b1001, 4'b1001, 1, 4'b1000, 0));
        tbl.push_back(mk(0, 4'b1001, 4'b1001, 1, 4'b0001, 0));
        tbl.push_back(mk(0, 4'b1001, 4'b1001, 1, 4'b1000, 0));
        tbl.push_back(mk(0, 4'b1001, 4'b1001, 1, 4'b0001, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0));
        // reset while locked on stream 2 with a beat in flight
        tbl.push_back(mk(0, 4'b0101, 4'b0000, 1, 4'b0100, 0));
        tbl.push_back(mk(1, 4'b0101, 4'b0000, 0, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 1, 4'b0001, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0));
        // non-locking instance: stream 2 (last=0) alternates with stream 3
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 1));
        tbl.push_back(mk(0, 4'b1100, 4'b0000, 1, 4'b0100, 1));
        tbl.push_back(mk(0, 4'b1100, 4'b0000, 1, 4'b1000, 1));
        tbl.push_back(mk(0, 4'b1100, 4'b0000, 1, 4'b0100, 1));
        tbl.push_back(mk(0, 4'b1100, 4'b0000, 1, 4'b1000, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1));

        for (int n = 0; n < tbl.size(); n++) begin
            curVec = n;
            applyStimulus(tbl[n]);
        end

        curVec = tbl.size();
        check("scoreboardEmpty", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
